slc3_control_fsm: RTL
=====================

// Module: slc3_control_fsm
// PURPOSE
//  Instruction sequencer for the SLC-3 datapath.
//  - Runs the fetch/decode/execute FSM and drives every load, gate and mux-select input of the datapath.
//  - Drives the memory strobes and counts fixed memory wait states.
//  - Sits between top level (Run/Continue switches, SRAM strobes) and datapath (IR, BEN feedback).
// PARAMETERS
//  MEM_WAIT  2  extra cycles memory strobe is held before data is valid/write done (1..7)
// PORTS
//  Clk        in   1   system clock, all state on rising edge
//  Reset      in   1   synchronous, active-low; forces HALTED
//  Run        in   1   level; leaves HALTED when high
//  Continue   in   1   level; resumes from PAUSE (release-then-press)
//  IR         in   16  instruction register from datapath
//  BEN        in   1   registered branch enable from datapath
//  LD_MAR,LD_MDR,LD_IR,LD_BEN,LD_CC,LD_REG,LD_PC,LD_LED  out 1 each  register loads
//  GatePC,GateMDR,GateALU,GateMARMUX  out 1 each  bus drivers, at most one high
//  PCMUX      out  2   00 PC+1, 01 bus, 10 adder
//  DRMUX      out  1   0 IR[11:9], 1 R7
//  SR1MUX     out  1   0 IR[11:9], 1 IR[8:6]
//  SR2MUX     out  1   0 register, 1 sext(IR[4:0])
//  ADDR1MUX   out  1   0 PC, 1 SR1
//  ADDR2MUX   out  2   00 zero, 01 off11, 10 off9, 11 off6
//  ALUK       out  2   00 ADD, 01 AND, 10 NOT A, 11 PASS A
//  MIO_EN     out  1   MDR loads from memory instead of bus
//  Mem_OE     out  1   memory read strobe, active high
//  Mem_WE     out  1   memory write strobe, active high
// BEHAVIOUR
//  - Moore FSM: outputs decode from the state register only.
//  - Default for every output is 0 / 00, which is also the reset value in HALTED.
//  - States and transitions:
//    HALTED -> F1 when Run=1.
//    F1: MAR<-PC, PC<-PC+1 (GatePC, LD_MAR, LD_PC, PCMUX=00) -> F2.
//    F2: Mem_OE=1, MIO_EN=1; wait counter loads MEM_WAIT, stays in F2 until count=0,
//        LD_MDR asserted only in the final F2 cycle -> F3.
//    F3: IR<-MDR (GateMDR, LD_IR) -> DEC.
//    DEC: LD_BEN=1, branch on IR[15:12]:
//         0001 ADD, 0101 AND, 1001 NOT: 1 cycle, GateALU, LD_REG, LD_CC, SR1MUX=1,
//              SR2MUX=IR[5], DRMUX=0 -> F1.
//         0000 BR -> BR0 (BEN valid there); BR0 with BEN=1: PCMUX=10, ADDR2MUX=10, LD_PC;
//              BEN=0: no loads; -> F1.
//         1100 JMP: PC<-SR1 via ADDR1MUX=1, ADDR2MUX=00, PCMUX=10, SR1MUX=1 -> F1.
//         0100 JSR: J0 R7<-PC (GatePC, DRMUX=1, LD_REG); J1 PC<-PC+off11 -> F1.
//         0110 LDR: L0 MAR<-SR1+off6 (GateMARMUX); L1 memory wait as F2; L2 DR<-MDR,
//              LD_CC -> F1.
//         0111 STR: S0 MAR<-SR1+off6; S1 MDR<-SR (SR1MUX=0, ALUK=11, GateALU, LD_MDR);
//              S2 Mem_WE held MEM_WAIT+1 cycles -> F1.
//         1101 PAUSE: P0 LD_LED 1 cycle; P1 wait Continue=1; P2 wait Continue=0 -> F1.
//         other opcodes: treated as NOP -> F1.
//  - Latencies with MEM_WAIT=2 (F1,F2x3,F3,DEC = 6-cycle fetch):
//    ADD = 7 total; LDR = 11.
//  - Reset mid-operation (any state, including during an active memory strobe):
//    next edge -> HALTED, all strobes drop at once, wait counter cleared.
//  - Run is sampled only in HALTED; dropping Run mid-program has no effect.
//  - The one-hot bus-gate invariant holds in every state; the bench asserts it.
// TESTING
//  1. Reset low 2 cycles, Run=1: F1 on the following cycle, GatePC=LD_MAR=LD_PC=1, all else 0.
//  2. IR=0x1261 (ADD R1,R1,#1), MEM_WAIT=2: GateALU,LD_REG,LD_CC,SR2MUX=1 in cycle 7 only.
//  3. IR=0x0E02 (BRnzp): BEN=1 -> LD_PC, PCMUX=10; BEN=0 -> no LD_PC in BR0.
//  4. IR=0x6243 (LDR): Mem_OE high exactly 3 cycles in L1; LD_MDR in 3rd; LD_REG, LD_CC in L2.
//  5. IR=0xD00F (PAUSE): LD_LED 1 cycle; holds in P1 until Continue=1; returns to F1 after release.
//  6. Reset low during S2 of STR: Mem_WE=0 next cycle; FSM in HALTED; no loads.

Source files
------------

// File: rtl/slc3_control_fsm.sv
// SLC-3 instruction sequencer: fetch/decode/execute Moore FSM driving datapath
// loads, bus gates, mux selects and memory strobes with a fixed wait-state count.
module slc3_control_fsm #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Continue,
  input  logic [15:0] IR,
  input  logic        BEN,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_BEN,
  output logic        LD_CC,
  output logic        LD_REG,
  output logic        LD_PC,
  output logic        LD_LED,
  output logic        GatePC,
  output logic        GateMDR,
  output logic        GateALU,
  output logic        GateMARMUX,
  output logic [1:0]  PCMUX,
  output logic        DRMUX,
  output logic        SR1MUX,
  output logic        SR2MUX,
  output logic        ADDR1MUX,
  output logic [1:0]  ADDR2MUX,
  output logic [1:0]  ALUK,
  output logic        MIO_EN,
  output logic        Mem_OE,
  output logic        Mem_WE
);

  typedef enum logic [4:0] {
    S_HALTED, S_F1, S_F2, S_F3, S_DEC,
    S_ALU, S_BR0, S_JMP, S_J0, S_J1,
    S_L0, S_L1, S_L2, S_S0, S_S1, S_S2,
    S_P0, S_P1, S_P2
  } state_e;

  localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [2:0] wait_q, wait_d;
  logic [3:0] opcode;
  logic       unused_ir;

  assign opcode    = IR[15:12];
  assign unused_ir = ^{IR[11:6], IR[4:0]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_HALTED;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_HALTED: if (Run) state_d = S_F1;
      S_F1: begin
        state_d = S_F2;
        wait_d  = WAIT_LOAD;
      end
      S_F2: begin
        if (wait_q == '0) state_d = S_F3;
        else              wait_d  = wait_q - 3'd1;
      end
      S_F3:  state_d = S_DEC;
      S_DEC: begin
        unique case (opcode)
          4'b0001, 4'b0101, 4'b1001: state_d = S_ALU;
          4'b0000: state_d = S_BR0;
          4'b1100: state_d = S_JMP;
          4'b0100: state_d = S_J0;
          4'b0110: state_d = S_L0;
          4'b0111: state_d = S_S0;
          4'b1101: state_d = S_P0;
          default: state_d = S_F1;
        endcase
      end
      S_ALU, S_BR0, S_JMP, S_J1, S_L2: state_d = S_F1;
      S_J0: state_d = S_J1;
      S_L0: begin
        state_d = S_L1;
        wait_d  = WAIT_LOAD;
      end
      S_L1: begin
        if (wait_q == '0) state_d = S_L2;
        else              wait_d  = wait_q - 3'd1;
      end
      S_S0: state_d = S_S1;
      S_S1: begin
        state_d = S_S2;
        wait_d  = WAIT_LOAD;
      end
      S_S2: begin
        if (wait_q == '0) state_d = S_F1;
        else              wait_d  = wait_q - 3'd1;
      end
      S_P0: state_d = S_P1;
      S_P1: if (Continue)  state_d = S_P2;
      S_P2: if (!Continue) state_d = S_F1;
      default: state_d = S_HALTED;
    endcase
  end

  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    ALUK       = 2'b00;
    MIO_EN     = 1'b0;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;
    unique case (state_q)
      S_F1: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
      end
      S_F2, S_L1: begin
        Mem_OE = 1'b1;
        MIO_EN = 1'b1;
        LD_MDR = (wait_q == '0);
      end
      S_F3: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S_DEC: LD_BEN = 1'b1;
      S_ALU: begin
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        SR1MUX  = 1'b1;
        SR2MUX  = IR[5];
        if (opcode == 4'b0101)      ALUK = 2'b01;
        else if (opcode == 4'b1001) ALUK = 2'b10;
      end
      S_BR0: begin
        // BEN is already registered by the datapath when BR0 is reached.
        if (BEN) begin
          LD_PC    = 1'b1;
          PCMUX    = 2'b10;
          ADDR2MUX = 2'b10;
        end
      end
      S_JMP: begin
        LD_PC    = 1'b1;
        PCMUX    = 2'b10;
        ADDR1MUX = 1'b1;
        SR1MUX   = 1'b1;
      end
      S_J0: begin
        GatePC = 1'b1;
        DRMUX  = 1'b1;
        LD_REG = 1'b1;
      end
      S_J1: begin
        LD_PC    = 1'b1;
        PCMUX    = 2'b10;
        ADDR2MUX = 2'b01;
      end
      S_L0, S_S0: begin
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = 2'b11;
        SR1MUX     = 1'b1;
      end
      S_L2: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_S1: begin
        GateALU = 1'b1;
        ALUK    = 2'b11;
        LD_MDR  = 1'b1;
      end
      S_S2: Mem_WE = 1'b1;
      S_P0: LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule
